// File: rtl/imm_encoder.sv
// Immediate encoder: range-checks an immediate for a RISC-V format and scatters it
// into an instruction template, through a two-stage valid/ready pipeline.
module imm_encoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_imm,
  input  logic [2:0]  io_in_immSrc,
  input  logic        io_in_immSign,
  input  logic [31:0] io_in_base,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic        io_out_err,
  output logic [7:0]  io_errCount
);

  typedef enum logic [2:0] {
    SRC_I   = 3'd0,
    SRC_S   = 3'd1,
    SRC_B   = 3'd2,
    SRC_U   = 3'd3,
    SRC_J   = 3'd4,
    SRC_CSR = 3'd5
  } immSrc_e;

  logic        r_s1Valid;
  logic [31:0] r_s1Inst;
  logic        r_s1Err;
  logic        r_s2Valid;
  logic [31:0] r_s2Inst;
  logic        r_s2Err;
  logic [7:0]  r_errCount;

  logic        w_inFire;
  logic        w_outFire;
  logic        w_s2Load;
  logic        w_signOk11;
  logic        w_signOk12;
  logic        w_signOk20;
  logic        w_ok;
  logic [31:0] w_mask;
  logic [31:0] w_field;
  logic [31:0] w_encInst;
  logic        w_err;

  // A sign-checked immediate fits when every bit above the field's sign bit matches it.
  assign w_signOk11 = (&io_in_imm[31:11]) | ~(|io_in_imm[31:11]);
  assign w_signOk12 = (&io_in_imm[31:12]) | ~(|io_in_imm[31:12]);
  assign w_signOk20 = (&io_in_imm[31:20]) | ~(|io_in_imm[31:20]);

  always_comb begin
    w_mask  = 32'h0000_0000;
    w_field = 32'h0000_0000;
    w_ok    = 1'b0;
    case (immSrc_e'(io_in_immSrc))
      SRC_I: begin
        w_mask  = 32'hFFF0_0000;
        w_field = {io_in_imm[11:0], 20'b0};
        w_ok    = io_in_immSign ? w_signOk11 : ~(|io_in_imm[31:12]);
      end
      SRC_S: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {io_in_imm[11:5], 13'b0, io_in_imm[4:0], 7'b0};
        w_ok    = io_in_immSign ? w_signOk11 : ~(|io_in_imm[31:12]);
      end
      SRC_B: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {io_in_imm[12], io_in_imm[10:5], 13'b0,
                   io_in_imm[4:1], io_in_imm[11], 7'b0};
        w_ok    = ~io_in_imm[0] &
                  (io_in_immSign ? w_signOk12 : ~(|io_in_imm[31:13]));
      end
      SRC_U: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {io_in_imm[31:12], 12'b0};
        w_ok    = ~(|io_in_imm[11:0]);
      end
      SRC_J: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {io_in_imm[20], io_in_imm[10:1], io_in_imm[11],
                   io_in_imm[19:12], 12'b0};
        w_ok    = ~io_in_imm[0] &
                  (io_in_immSign ? w_signOk20 : ~(|io_in_imm[31:21]));
      end
      SRC_CSR: begin
        w_mask  = 32'h000F_8000;
        w_field = {12'b0, io_in_imm[4:0], 15'b0};
        w_ok    = ~(|io_in_imm[31:5]);
      end
      default: begin
        w_ok    = 1'b0;
      end
    endcase
  end

  // Rejected immediates pass the template through untouched so the error is visible downstream.
  assign w_encInst = w_ok ? ((io_in_base & ~w_mask) | w_field) : io_in_base;
  assign w_err     = ~w_ok;

  assign io_in_ready = ~r_s1Valid | ~r_s2Valid | io_out_ready;
  assign w_inFire    = io_in_valid & io_in_ready;
  assign w_outFire   = r_s2Valid & io_out_ready;
  assign w_s2Load    = r_s1Valid & (~r_s2Valid | io_out_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1Valid <= 1'b0;
      r_s1Inst  <= 32'h0000_0000;
      r_s1Err   <= 1'b0;
    end else if (w_inFire) begin
      r_s1Valid <= 1'b1;
      r_s1Inst  <= w_encInst;
      r_s1Err   <= w_err;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2Valid <= 1'b0;
      r_s2Inst  <= 32'h0000_0000;
      r_s2Err   <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid <= 1'b1;
      r_s2Inst  <= r_s1Inst;
      r_s2Err   <= r_s1Err;
    end else if (w_outFire) begin
      r_s2Valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_errCount <= 8'h00;
    end else if (w_outFire && r_s2Err && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign io_out_valid = r_s2Valid;
  assign io_out_inst  = r_s2Inst;
  assign io_out_err   = r_s2Err;
  assign io_errCount  = r_errCount;

endmodule
